shift_issue_ctrl: RTL
=====================

SHIFT_ISSUE_CTRL -- requirements
Module: shift_issue_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, response buffer entries (power of two, >= 2).
REQ-002 SHALL have clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have req_valid  input  1  decoder presents a shift request.
REQ-005 SHALL have req_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have req_op  input  2  00 LSL, 01 LSR logical, 10 ASR, 11 ROR.
REQ-007 SHALL have req_data  input  16  operand.
REQ-008 SHALL have req_amt  input  16  shift amount, full 16-bit unsigned value.
REQ-009 SHALL have rsp_valid  output  1  response at buffer head.
REQ-010 SHALL have rsp_ready  input  1  consumer takes response.
REQ-011 SHALL have rsp_data  output  16  shifted result.
REQ-012 SHALL have rsp_flags  output  3  {N, Z, C} of rsp_data.
REQ-013 SHALL have busy  output  1  any request in flight or buffered.

Function
REQ-014 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; no other edge accepts.
REQ-015 SHALL compute the result in stage S1 (one register) and push it into the response FIFO on the next edge; minimum latency accept-to-rsp_valid is 2 edges.
REQ-016 SHALL drive req_ready = 1 iff fifo_count + s1_valid < FIFO_DEPTH; req_ready has no combinational path from rsp_ready or req_valid.
REQ-017 SHALL sustain one request per cycle indefinitely while rsp_ready is held 1.
REQ-018 SHALL pop the FIFO head on an edge where rsp_valid and rsp_ready are 1; rsp_data/rsp_flags hold stable while rsp_valid=1 and rsp_ready=0.
REQ-019 SHALL allow push and pop on the same edge at any occupancy, count unchanged at full.
REQ-020 SHALL wrap read/write pointers modulo FIFO_DEPTH.
REQ-021 SHALL, for amt 1..15: LSL fills zeros from bit 0; LSR fills zeros from bit 15; ASR fills copies of data[15]; ROR rotates right.
REQ-022 SHALL, for amt >= 16: LSL/LSR give 0, C = 0; ASR gives 16 copies of data[15], C = data[15]; ROR uses amt[3:0].
REQ-023 SHALL, for amt = 0 (and ROR amt[3:0] = 0): result = data, C = 0.
REQ-024 SHALL set C = last bit shifted out (LSL: data[16-amt]; LSR/ASR: data[amt-1]; ROR: result[15]).
REQ-025 SHALL set Z = (result == 0) and N = result[15].
REQ-026 SHALL drive busy = s1_valid | (fifo_count != 0).
REQ-027 SHALL preserve request order; responses leave in acceptance order.

Reset
REQ-028 SHALL on rst low asynchronously clear s1_valid, FIFO pointers and count; rsp_valid = 0, busy = 0, rsp_data = 0, rsp_flags = 0.
REQ-029 SHALL drive req_ready = 1 while rst is low and on the first edge after release.
REQ-030 SHALL discard any in-flight or buffered result when rst asserts mid-operation; none appears after release.

Structure
REQ-031 SHALL take op encodings, flag bit indices and default FIFO_DEPTH from shared package alu_pkg.
REQ-032 SHALL place the response buffer in sub-module shift_rsp_fifo (depth-parameterised, 19-bit entries, count output).
REQ-033 SHALL keep the shift/flag datapath in shift_issue_ctrl, no other sub-modules.

Verification
REQ-034 SHALL cover LSR 0x8F00 amt 4 -> rsp_data 0x08F0, flags N0 Z0 C0, rsp_valid 2 edges after accept.
REQ-035 SHALL cover ASR 0x8001 amt 15 -> 0xFFFF, N1 Z0 C0; ASR 0x8000 amt 20 -> 0xFFFF, C1; LSL 0x0030 amt 16 -> 0x0000, Z1 C0.
REQ-036 SHALL cover ROR 0x0001 amt 1 -> 0x8000, N1 C1; LSL 0x8001 amt 1 -> 0x0002, C1.
REQ-037 SHALL cover rsp_ready held 0, 6 back-to-back requests -> exactly FIFO_DEPTH accepted, req_ready 0 thereafter, then release drains in order.
REQ-038 SHALL cover rsp_ready held 1, 8 back-to-back requests -> req_ready never drops, 8 responses on 8 consecutive cycles.
REQ-039 SHALL cover rst asserted with 3 entries buffered -> rsp_valid and busy 0 immediately, no stale response after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift op encodings, flag bit positions and the
// response word layout used between the shift datapath and its buffer.
package alu_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_LSR = 2'b01;
    localparam logic [1:0] OP_ASR = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    localparam int FIFO_DEPTH_DEF = 4;
    localparam int RSP_W          = 19;

    typedef struct packed {
        logic [2:0]  flags;
        logic [15:0] data;
    } shift_rsp_t;

endpackage

// File: rtl/shift_rsp_fifo.sv
// Response buffer for the shift unit: DEPTH entries of one response word,
// simultaneous push/pop allowed at any occupancy, occupancy exported.
module shift_rsp_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [RSP_W-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [RSP_W-1:0]             head_o,
    output logic                         valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [RSP_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full, do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & (~full | do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // DEPTH is a power of two, so pointer increments wrap modulo DEPTH on their own.
    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; cleared pointers and count already make it empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/shift_issue_ctrl.sv
// Shift issue controller: computes LSL/LSR/ASR/ROR with N/Z/C flags into one
// pipeline register, then buffers results in order for the consumer.
module shift_issue_ctrl
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [15:0] req_data,
    input  logic [15:0] req_amt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic        busy
);
    localparam int              CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]     DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    logic [3:0]    sh, sh_neg;
    logic          big;
    logic [15:0]   res, rot;
    logic          carry;
    logic [2:0]    flags;
    logic          accept;
    logic          s1_valid_q, s1_valid_d;
    shift_rsp_t    s1_rsp_q, s1_rsp_d, fifo_head;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          fifo_valid;

    assign sh     = req_amt[3:0];
    assign sh_neg = 4'd0 - sh;
    assign big    = |req_amt[15:4];
    assign rot    = (req_data >> sh) | (req_data << sh_neg);

    // Amounts of 16 and above saturate except for ROR, which only looks at amt[3:0].
    always_comb begin
        res   = req_data;
        carry = 1'b0;
        case (req_op)
            OP_LSL: begin
                if (big) res = '0;
                else if (sh != 4'd0) begin
                    res   = req_data << sh;
                    carry = req_data[sh_neg];
                end
            end
            OP_LSR: begin
                if (big) res = '0;
                else if (sh != 4'd0) begin
                    res   = req_data >> sh;
                    carry = req_data[sh - 4'd1];
                end
            end
            OP_ASR: begin
                if (big) begin
                    res   = {16{req_data[15]}};
                    carry = req_data[15];
                end else if (sh != 4'd0) begin
                    res   = $signed(req_data) >>> sh;
                    carry = req_data[sh - 4'd1];
                end
            end
            default: begin
                if (sh != 4'd0) begin
                    res   = rot;
                    carry = rot[15];
                end
            end
        endcase
        flags         = '0;
        flags[FLAG_N] = res[15];
        flags[FLAG_Z] = (res == 16'h0000);
        flags[FLAG_C] = carry;
    end

    // Ready depends only on registered occupancy, never on this cycle's handshakes.
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
    assign req_ready  = (occupancy < DEPTH_V);
    assign accept     = req_valid & req_ready;
    assign s1_valid_d = accept;
    assign s1_rsp_d   = accept ? {flags, res} : s1_rsp_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_rsp_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rsp_q   <= s1_rsp_d;
        end
    end

    shift_rsp_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (s1_valid_q),
        .push_data_i (s1_rsp_q),
        .pop_i       (rsp_ready),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_count)
    );

    assign rsp_valid = fifo_valid;
    assign rsp_data  = fifo_valid ? fifo_head.data  : '0;
    assign rsp_flags = fifo_valid ? fifo_head.flags : '0;
    assign busy      = s1_valid_q | (fifo_count != '0);

endmodule
